// File: rtl/ka_seq_mult.sv
// ka_seq_mult: Karatsuba carry-less GF(2)[x] multiplier that reuses one H-bit clmul array
// across three cycles (lo, hi, mid), with valid/ready handshakes on both sides.
module ka_seq_mult #(
  parameter int N = 131
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*N-2:0] y,
  output logic           busy
);
  localparam int H = (N + 1) / 2;
  localparam int W = 2 * N - 1;
  typedef enum logic [2:0] {IDLE, MUL_LO, MUL_HI, MUL_MID, DONE} state_t;
  state_t state;
  logic [N-1:0] ra, rb;
  logic [2*H-2:0] p0, p1, pm;
  logic [H-1:0] a_lo, a_hi, b_lo, b_hi, mx, mz;
  function automatic logic [2*H-2:0] clmul(input logic [H-1:0] x, input logic [H-1:0] z);
    logic [2*H-2:0] r;
    r = '0;
    for (int i = 0; i < H; i++) if (z[i]) r ^= (2*H-1)'(x) << i;
    return r;
  endfunction
  assign a_lo = ra[H-1:0];
  assign b_lo = rb[H-1:0];
  assign a_hi = H'(ra >> H);
  assign b_hi = H'(rb >> H);
  // The single shared array: operand pair chosen by which partial product is due
  assign mx = state == MUL_LO ? a_lo : state == MUL_HI ? a_hi : a_lo ^ a_hi;
  assign mz = state == MUL_LO ? b_lo : state == MUL_HI ? b_hi : b_lo ^ b_hi;
  assign pm = clmul(mx, mz);
  assign in_ready = state == IDLE;
  assign busy = state != IDLE;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      ra <= '0;
      rb <= '0;
      p0 <= '0;
      p1 <= '0;
      y <= '0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          ra <= a;
          rb <= b;
          state <= MUL_LO;
        end
        MUL_LO: begin
          p0 <= pm;
          state <= MUL_HI;
        end
        MUL_HI: begin
          p1 <= pm;
          state <= MUL_MID;
        end
        MUL_MID: begin
          // Bits shifted past 2N-2 are always zero, so truncating to W is exact
          y <= W'(p0) ^ (W'(pm ^ p0 ^ p1) << H) ^ (W'(p1) << (2 * H));
          out_valid <= 1'b1;
          state <= DONE;
        end
        DONE: if (out_ready) begin
          out_valid <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ka_seq_mult.sv
// tb_ka_seq_mult: scoreboard bench for ka_seq_mult at N=131 against a bitwise schoolbook clmul model.
module tb_ka_seq_mult;
  localparam int N = 131;
  logic clk = 0, rst_n = 0, in_valid = 0, out_ready = 0;
  logic [N-1:0] a = '0, b = '0;
  logic in_ready, out_valid, busy;
  logic [2*N-2:0] y;
  int n_chk = 0, n_fail = 0;
  logic [2*N-2:0] q[$];
  ka_seq_mult #(.N(N)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready), .y(y), .busy(busy)
  );
  always #5 clk = ~clk;
  function automatic logic [N-1:0] rnd();
    return N'({$urandom(), $urandom(), $urandom(), $urandom(), $urandom()});
  endfunction
  function automatic logic [2*N-2:0] ref_mul(input logic [N-1:0] x, input logic [N-1:0] z);
    logic [2*N-2:0] r;
    r = '0;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) r[i+j] = r[i+j] ^ (x[i] & z[j]);
    return r;
  endfunction
  task automatic do_op(input logic [N-1:0] x, input logic [N-1:0] z, input logic [2*N-2:0] e,
                       input int hold, input string name);
    int k;
    logic [2*N-2:0] exp_y;
    @(negedge clk);
    a = x; b = z; in_valid = 1;
    k = 0;
    while (!in_ready && k < 20) begin @(negedge clk); k++; end
    n_chk++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL %s_accept: in_ready=%b required 1", name, in_ready); end
    @(posedge clk);
    q.push_back(e);
    @(negedge clk);
    in_valid = 0; a = rnd(); b = rnd();
    k = 1;
    while (!out_valid && k < 12) begin @(negedge clk); k++; a = rnd(); b = rnd(); end
    n_chk++;
    if (k != 4) begin n_fail++; $display("FAIL %s_latency: out_valid at negedge %0d required 4", name, k); end
    exp_y = q.pop_front();
    n_chk++;
    if (y !== exp_y) begin n_fail++; $display("FAIL %s_y: got %h required %h", name, y, exp_y); end
    n_chk++;
    if (in_ready !== 1'b0 || busy !== 1'b1)
      begin n_fail++; $display("FAIL %s_done_flags: in_ready=%b busy=%b required 0 1", name, in_ready, busy); end
    repeat (hold) begin
      a = rnd(); b = rnd(); in_valid = 1'($urandom_range(0, 1));
      @(negedge clk);
      n_chk++;
      if (y !== exp_y || in_ready !== 1'b0 || out_valid !== 1'b1)
        begin n_fail++; $display("FAIL %s_hold: y=%h in_ready=%b out_valid=%b required %h 0 1", name, y, in_ready, out_valid, exp_y); end
    end
    in_valid = 0; out_ready = 1;
    @(negedge clk);
    out_ready = 0;
    n_chk++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || y !== exp_y)
      begin n_fail++; $display("FAIL %s_drain: out_valid=%b in_ready=%b y=%h required 0 1 %h", name, out_valid, in_ready, y, exp_y); end
  endtask
  task automatic test_reset();
    @(negedge clk);
    n_chk++;
    if (out_valid !== 1'b0 || y !== '0 || in_ready !== 1'b1 || busy !== 1'b0)
      begin n_fail++; $display("FAIL reset: out_valid=%b y=%h in_ready=%b busy=%b required 0 0 1 0", out_valid, y, in_ready, busy); end
    rst_n = 1;
    out_ready = 1;
    @(negedge clk);
    out_ready = 0;
    n_chk++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1)
      begin n_fail++; $display("FAIL idle_out_ready: out_valid=%b in_ready=%b required 0 1", out_valid, in_ready); end
  endtask
  task automatic test_basic();
    do_op(N'(1), N'(1), (2*N-1)'(1), 0, "one_by_one");
    do_op(N'(3), N'(3), (2*N-1)'(5), 2, "three_sq");
    do_op(N'(7), N'(3), (2*N-1)'(9), 1, "seven_three");
  endtask
  task automatic test_boundary();
    logic [N-1:0] top;
    logic [2*N-2:0] e;
    top = '0; top[N-1] = 1'b1;
    e = '0; e[2*N-2] = 1'b1;
    do_op(top, top, e, 0, "top_sq");
    do_op('1, N'(1), (2*N-1)'({N{1'b1}}), 0, "ones_by_one");
    do_op('1, '1, ref_mul('1, '1), 0, "ones_sq");
  endtask
  task automatic test_hold();
    logic [N-1:0] x, z;
    x = rnd(); z = rnd();
    do_op(x, z, ref_mul(x, z), 6, "hold6");
  endtask
  task automatic test_reset_mid();
    @(negedge clk);
    a = rnd(); b = rnd(); in_valid = 1;
    @(negedge clk);
    in_valid = 0;
    @(negedge clk);
    rst_n = 0;
    @(negedge clk);
    n_chk++;
    if (out_valid !== 1'b0 || y !== '0 || in_ready !== 1'b1 || busy !== 1'b0)
      begin n_fail++; $display("FAIL reset_mid: out_valid=%b y=%h in_ready=%b busy=%b required 0 0 1 0", out_valid, y, in_ready, busy); end
    rst_n = 1;
    do_op(N'(7), N'(3), (2*N-1)'(9), 0, "after_reset");
  endtask
  task automatic test_random(input int cnt);
    logic [N-1:0] x, z;
    for (int i = 0; i < cnt; i++) begin
      x = rnd(); z = rnd();
      if (i % 7 == 0) x = x & rnd() & rnd();
      if (i % 11 == 0) z = N'(1) << $urandom_range(0, N - 1);
      do_op(x, z, ref_mul(x, z), i % 3, "random");
    end
  endtask
  task automatic test_back_to_back();
    logic [N-1:0] x, z;
    for (int i = 0; i < 8; i++) begin
      x = rnd(); z = rnd();
      do_op(x, z, ref_mul(x, z), 0, "b2b");
    end
    n_chk++;
    if (q.size() != 0) begin n_fail++; $display("FAIL scoreboard_empty: %0d left required 0", q.size()); end
  endtask
  initial begin
    test_reset();
    test_basic();
    test_boundary();
    test_hold();
    test_reset_mid();
    test_random(1500);
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
